fm_iq_modulator: RTL and testbench

FM_IQ_MODULATOR -- requirements
Module: fm_iq_modulator

---
 rtl/fm_iq_modulator_if.sv | 20 ++
 rtl/fm_iq_modulator.sv | 113 +++++++++++
 tb/tb_fm_iq_modulator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fm_iq_modulator_if.sv
// Sample-in / IQ-byte-out bus of the FM IQ modulator.
// The master drives audio samples; the slave answers with ready and the interleaved I/Q bytes.
interface fm_iq_modulator_if;
   logic        start_i;
   logic [15:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_o;
   logic        valid_o;

   modport master (
      output start_i, data_i, valid_i,
      input  ready_o, data_o, valid_o
   );

   modport slave (
      input  start_i, data_i, valid_i,
      output ready_o, data_o, valid_o
   );
endinterface

// File: rtl/fm_iq_modulator.sv
// FM modulator: accumulates scaled audio into a 16-bit phase.
// Each sample becomes an interleaved cos/sin byte pair, I first and then Q.
module fm_iq_modulator #(
   parameter int DEV_SHIFT = 4,
   parameter int LUT_BITS  = 6
) (
   input  logic clk,
   input  logic rst,
   fm_iq_modulator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EMIT_I, EMIT_Q} state_t;

   localparam int LUT_SIZE = 1 << LUT_BITS;

   state_t              state_reg, state_next;
   logic [15:0]         phase_reg, phase_next;
   logic [7:0]          data_reg, data_next;
   logic                valid_reg, valid_next;
   logic                accept;
   logic signed [15:0]  incr;
   logic [LUT_BITS-1:0] lut_idx;
   logic [7:0]          cos_lut [0:LUT_SIZE-1];
   logic [7:0]          sin_lut [0:LUT_SIZE-1];

   // First quadrant of round(127*cos(2*pi*k/64)); the rest of the circle follows by symmetry.
   function automatic logic [7:0] quarter(input int k);
      case (k)
         0:       return 8'd127;
         1:       return 8'd126;
         2:       return 8'd125;
         3:       return 8'd122;
         4:       return 8'd117;
         5:       return 8'd112;
         6:       return 8'd106;
         7:       return 8'd98;
         8:       return 8'd90;
         9:       return 8'd81;
         10:      return 8'd71;
         11:      return 8'd60;
         12:      return 8'd49;
         13:      return 8'd37;
         14:      return 8'd25;
         15:      return 8'd12;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] cos_val(input int k);
      int m;
      m = k % 64;
      if (m <= 16)      return quarter(m);
      else if (m <= 32) return -quarter(32 - m);
      else if (m <= 48) return -quarter(m - 32);
      else              return quarter(64 - m);
   endfunction

   // sin(k) = cos(k - 16) on a 64-step circle.
   genvar gi;
   generate
      for (gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
         assign cos_lut[gi] = cos_val(gi);
         assign sin_lut[gi] = cos_val(gi + 48);
      end
   endgenerate

   assign incr        = $signed(bus.data_i) >>> DEV_SHIFT;
   assign lut_idx     = phase_reg[15 -: LUT_BITS];
   assign bus.ready_o = bus.start_i && (state_reg == IDLE || state_reg == EMIT_Q);
   assign accept      = bus.valid_i && bus.ready_o;
   assign bus.data_o  = data_reg;
   assign bus.valid_o = valid_reg;

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      if (accept) phase_next = phase_reg + $unsigned(incr);
      case (state_reg)
         IDLE: begin
            if (accept) state_next = EMIT_I;
         end
         EMIT_I: begin
            state_next = EMIT_Q;
            data_next  = cos_lut[lut_idx];
            valid_next = 1'b1;
         end
         EMIT_Q: begin
            // Q uses the pre-update phase; a new sample may be accepted on this same edge.
            state_next = accept ? EMIT_I : IDLE;
            data_next  = sin_lut[lut_idx];
            valid_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         phase_reg <= 16'd0;
         data_reg  <= 8'd0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
      end
   end

endmodule

// File: tb/tb_fm_iq_modulator.sv
// Randomized and directed bench for fm_iq_modulator.
// A queue-based reference model predicts every output cycle.
module tb_fm_iq_modulator;

   localparam int DEV_SHIFT = 4;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b0;
   fm_iq_modulator_if bus();

   fm_iq_modulator #(.DEV_SHIFT(DEV_SHIFT), .LUT_BITS(6)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int  tests = 0;
   int  fails = 0;
   byte outq[$];
   byte got[$];
   int  m_phase = 0;
   bit  m_rdy;
   byte exp_data = 0;
   bit  exp_valid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Ideal table value straight from trigonometry, rounded half away from zero.
   function automatic byte lut(input int k, input bit is_sin);
      real a, x;
      a = 2.0 * PI * real'(k) / 64.0;
      x = 127.0 * (is_sin ? $sin(a) : $cos(a));
      if (x >= 0.0) return byte'($rtoi(x + 0.5));
      else          return byte'(-$rtoi(-x + 0.5));
   endfunction

   // Reference model: each accepted sample queues its I and Q byte, one byte leaves per edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase   = 0;
         outq.delete();
         exp_data  = 0;
         exp_valid = 1'b0;
      end else begin
         m_rdy = bus.start_i && (outq.size() <= 1);
         if (outq.size() > 0) begin
            exp_data  = outq.pop_front();
            exp_valid = 1'b1;
         end else begin
            exp_valid = 1'b0;
         end
         if (m_rdy && bus.valid_i) begin
            m_phase = (m_phase + (int'($signed(bus.data_i)) >>> DEV_SHIFT)) & 16'hFFFF;
            outq.push_back(lut(m_phase >> 10, 1'b0));
            outq.push_back(lut(m_phase >> 10, 1'b1));
         end
      end
   end

   always @(negedge clk) begin
      check("valid_o", int'(bus.valid_o), int'(exp_valid));
      check("data_o", int'($signed(bus.data_o)), int'(exp_data));
      check("ready_o", int'(bus.ready_o), int'(bus.start_i && (outq.size() <= 1)));
      if (bus.valid_o) begin
         got.push_back(byte'(bus.data_o));
         if (got.size() % 2 == 0)
            $display("[TB] pair I=%0d Q=%0d", got[got.size()-2], got[got.size()-1]);
      end
   end

   task automatic cyc(input bit s, input bit v, input logic [15:0] d);
      bus.start_i = s;
      bus.valid_i = v;
      bus.data_i  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      got.delete();
   endtask

   initial begin
      bus.start_i = 1'b1;
      bus.valid_i = 1'b0;
      bus.data_i  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("reset_valid", int'(bus.valid_o), 0);
      check("reset_data", int'(bus.data_o), 0);
      check("reset_ready", int'(bus.ready_o), 1);
      @(posedge clk);
      #1;

      // Zero deviation: constant carrier (127, 0).
      got.delete();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 16'd0);
      idle(4);
      check("zero_count", got.size(), 8);
      for (int i = 0; i < got.size(); i++) check("zero_byte", got[i], (i % 2 == 0) ? 127 : 0);

      // Tone: one table step per sample, full turn in 64 samples.
      do_reset();
      for (int i = 0; i < 128; i++) cyc(1'b1, 1'b1, 16'd16384);
      idle(4);
      check("tone_count", got.size(), 128);
      check("tone_p1_i", got[0], 126);
      check("tone_p1_q", got[1], 12);
      check("tone_p16_i", got[30], 0);
      check("tone_p16_q", got[31], 127);
      check("tone_p32_i", got[62], -127);
      check("tone_p32_q", got[63], 0);
      check("tone_p64_i", got[126], 127);
      check("tone_p64_q", got[127], 0);

      // Negative deviation wraps phase to 0xFC00.
      do_reset();
      cyc(1'b1, 1'b1, 16'hC000);
      idle(4);
      check("neg_count", got.size(), 2);
      check("neg_i", got[0], 126);
      check("neg_q", got[1], -12);
      check("neg_valid_after", int'(bus.valid_o), 0);
      check("neg_ready_after", int'(bus.ready_o), 1);

      // Sparse pulses: exactly one pair per pulse.
      do_reset();
      for (int p = 0; p < 6; p++) begin
         cyc(1'b1, 1'b1, 16'($urandom));
         idle(4);
      end
      check("gap_count", got.size(), 12);

      // start_i drops mid-pair: the pair completes, nothing new is taken.
      do_reset();
      cyc(1'b1, 1'b1, 16'd16384);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'd16384);
      check("stop_count", got.size(), 2);

      // Reset right after the I byte: Q is dropped, the next sample starts fresh.
      do_reset();
      cyc(1'b1, 1'b1, 16'd16384);
      cyc(1'b1, 1'b0, 16'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(3);
      check("midrst_count", got.size(), 1);
      check("midrst_i", got[0], 126);
      got.delete();
      cyc(1'b1, 1'b1, 16'd16384);
      idle(4);
      check("midrst_next_count", got.size(), 2);
      check("midrst_next_i", got[0], 126);
      check("midrst_next_q", got[1], 12);

      // Random traffic with occasional resets; the model checks every cycle.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b0;
            cyc(1'b1, 1'b0, 16'd0);
            rst = 1'b1;
         end
         cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 16'($urandom));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
